// File: rtl/spi_pkg.sv
// spi_pkg: shared data width and feeder FSM state encoding.
package spi_pkg;
   localparam int SPI_DATA_W = 12;
   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE} state_t;
endpackage

// File: rtl/spi_sync_fifo.sv
// spi_sync_fifo: synchronous FIFO; head is the oldest word, count is the occupancy.
// Ports: clk, reset (sync, active-high), push/din write side, pop/head read side,
//        count/full/empty status. A push while full is dropped even if a pop coincides.
module spi_sync_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 12
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic [W-1:0]           din,
   input  logic                   pop,
   output logic [W-1:0]           head,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wp, r_rp;
   logic [AW:0]   r_cnt;
   logic          w_push, w_pop;
   assign full   = r_cnt == (AW+1)'(DEPTH);
   assign empty  = r_cnt == '0;
   assign count  = r_cnt;
   assign head   = r_mem[r_rp];
   assign w_push = push && !full;
   assign w_pop  = pop && !empty;
   always_ff @(posedge clk)
      if (w_push) r_mem[r_wp] <= din;
   // pointers are AW bits wide, so they wrap modulo DEPTH on their own
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         r_wp  <= w_push ? r_wp + 1'b1 : r_wp;
         r_rp  <= w_pop ? r_rp + 1'b1 : r_rp;
         r_cnt <= r_cnt + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
      end
   end
endmodule

// File: rtl/spi_tx_feeder.sv
// spi_tx_feeder: queues words and feeds them one at a time to an SPI master, collecting replies.
// Ports: clk, reset (sync, active-high); wr_en/wr_data/full/count/overflow producer side;
//        spi_din/spi_new_data/spi_done/spi_dout SPI side; rx_data/rx_valid/timeout results.
// Optional: SPI_FEEDER_LOOPBACK_CHECK_EN adds output mismatch, pulsing with rx_valid when the
//        returned word differs from the word sent.
module spi_tx_feeder
   import spi_pkg::*;
#(
   parameter int DEPTH   = 8,
   parameter int TIMEOUT = 255
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   wr_en,
   input  logic [SPI_DATA_W-1:0]  wr_data,
   output logic                   full,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow,
   output logic [SPI_DATA_W-1:0]  spi_din,
   output logic                   spi_new_data,
   input  logic                   spi_done,
   input  logic [SPI_DATA_W-1:0]  spi_dout,
   output logic [SPI_DATA_W-1:0]  rx_data,
   output logic                   rx_valid,
   output logic                   timeout
`ifdef SPI_FEEDER_LOOPBACK_CHECK_EN
   ,
   output logic                   mismatch
`endif
);
   localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   state_t                r_state, w_next;
   logic [TW-1:0]         r_wait;
   logic [SPI_DATA_W-1:0] r_din, r_rx, w_head;
   logic                  r_ovf, r_rxv, r_tmo, w_empty, w_done, w_tmo;
   spi_sync_fifo #(.DEPTH(DEPTH), .W(SPI_DATA_W)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (wr_en),
      .din   (wr_data),
      .pop   (r_state == LAUNCH),
      .head  (w_head),
      .count (count),
      .full  (full),
      .empty (w_empty)
   );
   assign spi_new_data = r_state == LAUNCH;
   assign spi_din      = r_din;
   assign rx_data      = r_rx;
   assign rx_valid     = r_rxv;
   assign timeout      = r_tmo;
   assign overflow     = r_ovf;
   always_comb begin
      w_next = r_state;
      w_done = 1'b0;
      w_tmo  = 1'b0;
      case (r_state)
         IDLE:      w_next = w_empty ? IDLE : LAUNCH;
         LAUNCH:    w_next = WAIT_DONE;
         WAIT_DONE: begin
            w_done = spi_done;
            w_tmo  = !spi_done && r_wait == TW'(TIMEOUT - 1);
            w_next = (w_done || w_tmo) ? IDLE : WAIT_DONE;
         end
         default:   w_next = IDLE;
      endcase
   end
   // spi_din is captured on the IDLE->LAUNCH edge so the head word is already
   // on the bus while the strobe is high, then held until the next launch
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_wait  <= '0;
         r_din   <= '0;
         r_rx    <= '0;
         r_rxv   <= 1'b0;
         r_tmo   <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_wait  <= (r_state == WAIT_DONE) ? r_wait + 1'b1 : '0;
         r_din   <= (r_state == IDLE && !w_empty) ? w_head : r_din;
         r_rx    <= w_done ? spi_dout : r_rx;
         r_rxv   <= w_done;
         r_tmo   <= w_tmo;
         r_ovf   <= wr_en && full;
      end
   end
`ifdef SPI_FEEDER_LOOPBACK_CHECK_EN
   always_ff @(posedge clk)
      mismatch <= !reset && w_done && spi_dout != r_din;
`endif
endmodule

// File: tb/tb_spi_tx_feeder.sv
// tb_spi_tx_feeder: randomized directed bench with a queue-based reference model and SPI responder.
module tb_spi_tx_feeder;
   localparam int DEPTH = 8, TIMEOUT = 255, CW = $clog2(DEPTH) + 1;
   logic          clk = 1'b0, reset = 1'b1, wr_en = 1'b0, spi_done = 1'b0;
   logic [11:0]   wr_data = '0, spi_dout = '0;
   logic          full, overflow, spi_new_data, rx_valid, timeout;
   logic [CW-1:0] count;
   logic [11:0]   spi_din, rx_data;
`ifdef SPI_FEEDER_LOOPBACK_CHECK_EN
   logic          mismatch;
`endif
   spi_tx_feeder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk          (clk),
      .reset        (reset),
      .wr_en        (wr_en),
      .wr_data      (wr_data),
      .full         (full),
      .count        (count),
      .overflow     (overflow),
      .spi_din      (spi_din),
      .spi_new_data (spi_new_data),
      .spi_done     (spi_done),
      .spi_dout     (spi_dout),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .timeout      (timeout)
`ifdef SPI_FEEDER_LOOPBACK_CHECK_EN
      ,
      .mismatch     (mismatch)
`endif
   );
   always #5 clk = ~clk;
   logic [11:0] q[$];
   logic [11:0] din_m = '0, rx_m = '0, resp_word = '0;
   bit          busy, pend, str_now, no_done;
   int          cyc, done_at = -1, end_at = -1, kind, lat_lo = 20, lat_hi = 20, resp_sel;
   int          nassert, nfail;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nassert++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h at cycle %0d", tag, obs, exp, cyc);
      end
   endtask
   task automatic tick();
      bit exp_ovf, acc, pop, exp_new, exp_rxv, exp_tmo, exp_mm;
      int lat;
      exp_ovf = !reset && wr_en && q.size() == DEPTH;
      acc     = !reset && wr_en && q.size() < DEPTH;
      pop     = str_now;
      exp_new = pend && !reset;
      @(posedge clk);
      #1;
      cyc++;
      exp_rxv = 0;
      exp_tmo = 0;
      exp_mm  = 0;
      str_now = 0;
      if (reset) begin
         q.delete();
         busy = 0;
         din_m = '0;
         rx_m = '0;
         done_at = -1;
         end_at = -1;
      end else begin
         if (pop) void'(q.pop_front());
         if (acc) q.push_back(wr_data);
         if (cyc == end_at) begin
            busy = 0;
            exp_rxv = kind == 1;
            exp_tmo = kind == 2;
            if (kind == 1) begin
               rx_m = resp_word;
               exp_mm = resp_word != din_m;
            end
         end
         if (exp_new) begin
            din_m = q[0];
            busy = 1;
            str_now = 1;
            lat = $urandom_range(lat_hi, lat_lo);
            if (no_done) begin
               kind = 2;
               done_at = -1;
               end_at = cyc + TIMEOUT + 1;
            end else begin
               kind = 1;
               done_at = cyc + lat;
               end_at = cyc + lat + 1;
               resp_word = resp_sel == 0 ? din_m : resp_sel == 1 ? 12'($urandom) : 12'h000;
            end
         end
      end
      chk("count", 32'(count), q.size());
      chk("full", full, q.size() == DEPTH);
      chk("overflow", overflow, exp_ovf);
      chk("spi_new_data", spi_new_data, exp_new);
      chk("spi_din", spi_din, din_m);
      chk("rx_valid", rx_valid, exp_rxv);
      chk("timeout", timeout, exp_tmo);
      chk("rx_data", rx_data, rx_m);
`ifdef SPI_FEEDER_LOOPBACK_CHECK_EN
      chk("mismatch", mismatch, exp_mm);
`endif
      pend = !busy && q.size() > 0;
      spi_done = (cyc == done_at) || (!busy && $urandom_range(3) == 0);
      spi_dout = (cyc == done_at) ? resp_word : 12'($urandom);
   endtask
   task automatic push(input logic [11:0] w);
      wr_en = 1'b1;
      wr_data = w;
      tick();
      wr_en = 1'b0;
   endtask
   task automatic drain(input int bound);
      int n = 0;
      while ((busy || pend || q.size() > 0) && n < bound) begin
         tick();
         n++;
      end
      chk("drain_bound", busy || pend || q.size() > 0, 0);
      repeat (2) tick();
   endtask
   initial begin
      repeat (2) tick();
      reset = 1'b0;
      tick();
      // single word, done 20 cycles after the strobe, echoed back
      push(12'd5);
      drain(100);
      chk("single_rx_data", rx_data, 12'd5);
      // burst while a long transfer holds the FSM: fill to full, then overflow
      lat_lo = 200;
      lat_hi = 200;
      push(12'h100);
      repeat (2) tick();
      lat_lo = 1;
      lat_hi = 30;
      resp_sel = 1;
      for (int i = 1; i <= 8; i++) push(12'(i));
      chk("burst_full", full, 1'b1);
      push(12'd9);
      chk("burst_overflow", overflow, 1'b1);
      drain(2000);
      // timeout on 0xABC, then the queued word still goes out
      no_done = 1;
      push(12'hABC);
      push(12'h123);
      for (int n = 0; n < 10 && !busy; n++) tick();
      no_done = 0;
      lat_lo = 20;
      lat_hi = 20;
      drain(800);
      // reset during WAIT_DONE with words queued; push coinciding with reset
      lat_lo = 100;
      lat_hi = 100;
      resp_sel = 0;
      push(12'h011);
      push(12'h022);
      push(12'h033);
      repeat (5) tick();
      reset = 1'b1;
      wr_en = 1'b1;
      wr_data = 12'h777;
      tick();
      reset = 1'b0;
      wr_en = 1'b0;
      chk("rst_count", 32'(count), 0);
      repeat (120) tick();
      // pointer wrap: one word at a time, short transfers
      lat_lo = 1;
      lat_hi = 1;
      resp_sel = 1;
      for (int i = 0; i < 20; i++) begin
         push(12'($urandom));
         for (int n = 0; n < 10 && (busy || pend); n++) tick();
      end
      // random traffic across many wraps
      lat_lo = 1;
      lat_hi = 6;
      for (int i = 0; i < 300; i++) begin
         wr_en = $urandom_range(4) < 2;
         wr_data = 12'($urandom);
         tick();
      end
      wr_en = 1'b0;
      drain(2000);
      // loopback: differing reply, then equal reply
      lat_lo = 4;
      lat_hi = 4;
      resp_sel = 2;
      push(12'h0F0);
      drain(50);
      resp_sel = 0;
      push(12'h0F0);
      drain(50);
      chk("loop_rx_data", rx_data, 12'h0F0);
      $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
      $finish;
   end
endmodule

// File: doc/spi_tx_feeder.md
SPI_TX_FEEDER -- requirements
Module: spi_tx_feeder

Interface
REQ-001 SHALL have a single clock, clk; reset is synchronous and active-high, named reset.
REQ-002 SHALL take parameter DEPTH, default 8, as the FIFO depth in words (power of two, 2..64).
REQ-003 SHALL take parameter TIMEOUT, default 255, as the maximum number of cycles to wait for spi_done.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port reset  input  1  synchronous active-high reset.
REQ-006 SHALL have port wr_en  input  1  push request from the producer.
REQ-007 SHALL have port wr_data  input  12  word to transmit.
REQ-008 SHALL have port full  output  1  FIFO holds DEPTH words.
REQ-009 SHALL have port count  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-010 SHALL have port overflow  output  1  one-cycle pulse when a push is dropped.
REQ-011 SHALL have port spi_din  output  12  word presented to the SPI top.
REQ-012 SHALL have port spi_new_data  output  1  one-cycle start strobe to the SPI top.
REQ-013 SHALL have port spi_done  input  1  transfer-complete from the SPI top.
REQ-014 SHALL have port spi_dout  input  12  word returned by the SPI top.
REQ-015 SHALL have port rx_data  output  12  captured spi_dout.
REQ-016 SHALL have port rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-017 SHALL have port timeout  output  1  one-cycle pulse when a transfer is abandoned.

Function
REQ-018 SHALL accept a push only when wr_en=1 and full=0. A push with full=1 SHALL be dropped and pulse overflow for 1 cycle, even if a pop occurs in the same cycle.
REQ-019 SHALL implement FSM states IDLE, LAUNCH and WAIT_DONE.
REQ-020 In IDLE with count>0, the FSM SHALL go to LAUNCH on the next edge. With count=0 it SHALL stay in IDLE.
REQ-021 In LAUNCH, the block SHALL drive spi_new_data=1 and load spi_din with the FIFO head word. It SHALL pop that word, go to WAIT_DONE, and clear the wait counter.
REQ-022 spi_new_data SHALL be high for exactly one cycle per word; it SHALL be 0 in all other states.
REQ-023 spi_din SHALL stay stable from LAUNCH until the next LAUNCH.
REQ-024 In WAIT_DONE with spi_done=1, the block SHALL register spi_dout into rx_data, pulse rx_valid for 1 cycle and return to IDLE.
REQ-025 In WAIT_DONE, the wait counter SHALL increment each cycle. When it reaches TIMEOUT with spi_done=0, the block SHALL pulse timeout, return to IDLE and keep rx_data unchanged.
REQ-026 spi_done outside WAIT_DONE SHALL be ignored.
REQ-027 Latency: a push into an empty FIFO while the FSM is idle at edge E0 SHALL produce spi_new_data high between E1 and E2.
REQ-028 A push and a pop in the same cycle with 0<count<DEPTH SHALL leave count unchanged.
REQ-029 FIFO pointers SHALL wrap modulo DEPTH.

Reset
REQ-030 On reset=1 at a clock edge, the block SHALL set: FSM=IDLE, FIFO empty, count=0, full=0, overflow=0, spi_new_data=0, spi_din=0, rx_data=0, rx_valid=0, timeout=0.
REQ-031 Reset mid-transfer SHALL discard all queued words and the in-flight word, and SHALL emit no rx_valid for them.
REQ-032 A push coinciding with reset SHALL be dropped.

Configuration
REQ-033 SHALL support macro SPI_FEEDER_LOOPBACK_CHECK_EN. When defined, the block SHALL add output mismatch (1 bit). mismatch SHALL pulse with rx_valid when spi_dout differs from spi_din.
REQ-034 When SPI_FEEDER_LOOPBACK_CHECK_EN is undefined, the mismatch port and its logic SHALL be absent.

Structure
REQ-035 Package spi_pkg SHALL hold constant SPI_DATA_W=12 and the FSM state enum.
REQ-036 The FIFO SHALL be a sub-module spi_sync_fifo, parameterised on DEPTH and the data width.

Verification
REQ-037 Single word: push 12'd5 with SPI returning done 20 cycles after the strobe, spi_dout=12'd5 -> one spi_new_data pulse with spi_din=5, then rx_valid with rx_data=5.
REQ-038 Burst: push 8 words 1..8 back-to-back (DEPTH=8) -> full=1 after the 8th push; a 9th push pulses overflow; words are launched in order 1..8 and each waits for spi_done.
REQ-039 Timeout: push 12'hABC and never assert spi_done -> timeout pulses TIMEOUT cycles after the strobe, rx_valid never asserts, and the next queued word is launched.
REQ-040 Reset mid-transfer: 3 words queued, reset asserted during WAIT_DONE -> count=0 and spi_new_data=0 after reset, with no rx_valid.
REQ-041 Loopback (macro defined): spi_dout=12'h000 returned for spi_din=12'h0F0 -> mismatch=1 together with rx_valid. Equal words -> mismatch=0.
REQ-042 Wrap: 20 push/pop cycles at count=1 -> data intact across pointer wrap-around.
